// File: rtl/regfile_write_scheduler.sv
// Shares the register_file write port between ALU writeback and load returns (FIFO-buffered on collision)
// and tracks in-flight loads for hazard stalls. Optional forwarding: define REGFILE_SCHED_FWD_EN.
module regfile_write_scheduler #(
  parameter int LD_DEPTH = 2,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_wr_valid,
  input  logic [4:0]        alu_wr_reg,
  input  logic [31:0]       alu_wr_data,
  input  logic              ld_issue_valid,
  input  logic [4:0]        ld_issue_reg,
  input  logic              ld_valid,
  input  logic [4:0]        ld_reg,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  input  logic [4:0]        chk_reg_a,
  input  logic [4:0]        chk_reg_b,
  input  logic [4:0]        chk_reg_d,
  output logic              stall,
  output logic              reg_write_enable,
  output logic [4:0]        write_reg_rd,
  output logic [31:0]       reg_write_data,
  output logic              fwd_valid_a,
  output logic              fwd_valid_b,
  output logic [31:0]       fwd_data,
  output logic [CNT_W-1:0]  ld_count,
  output logic              ld_overflow
);
  localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;

  logic [4:0]       buf_reg_q  [LD_DEPTH];
  logic [4:0]       buf_reg_d  [LD_DEPTH];
  logic [31:0]      buf_data_q [LD_DEPTH];
  logic [31:0]      buf_data_d [LD_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_q, pend_d;
  logic             ovf_q, ovf_d;

  logic             accept, pop, bypass, push, ld_wins, sel_vld, supp;
  logic [4:0]       sel_reg;
  logic [31:0]      sel_data;

  always_comb begin
    ld_ready = cnt_q < CNT_W'(LD_DEPTH);
    accept   = ld_valid && ld_ready;
    pop      = 1'b0;
    bypass   = 1'b0;
    sel_vld  = 1'b0;
    sel_reg  = '0;
    sel_data = '0;
    // Port is held idle while reset is asserted, whatever state is still around.
    if (!reset) begin
      if (alu_wr_valid) begin
        sel_vld  = 1'b1;
        sel_reg  = alu_wr_reg;
        sel_data = alu_wr_data;
      end else if (cnt_q != '0) begin
        pop      = 1'b1;
        sel_vld  = 1'b1;
        sel_reg  = buf_reg_q[head_q];
        sel_data = buf_data_q[head_q];
      end else if (accept) begin
        bypass   = 1'b1;
        sel_vld  = 1'b1;
        sel_reg  = ld_reg;
        sel_data = ld_data;
      end
    end
    ld_wins = pop || bypass;
    push    = accept && !bypass;

    reg_write_enable = sel_vld && (sel_reg != '0);
    write_reg_rd     = sel_reg;
    reg_write_data   = sel_data;

    buf_reg_d  = buf_reg_q;
    buf_data_d = buf_data_q;
    head_d     = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d     = push ? tail_q + PTR_W'(1) : tail_q;
    if (push) begin
      buf_reg_d[tail_q]  = ld_reg;
      buf_data_d[tail_q] = ld_data;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // A dropped load keeps its pending bit: the consumer must not read a value that never arrived.
    ovf_d  = ovf_q || (ld_valid && !ld_ready);
    pend_d = pend_q;
    if (ld_wins)        pend_d[sel_reg]      = 1'b0;
    if (ld_issue_valid) pend_d[ld_issue_reg] = 1'b1;
    pend_d[0] = 1'b0;

`ifdef REGFILE_SCHED_FWD_EN
    fwd_data    = reg_write_data;
    fwd_valid_a = reg_write_enable && (write_reg_rd == chk_reg_a) && (chk_reg_a != '0);
    fwd_valid_b = reg_write_enable && (write_reg_rd == chk_reg_b) && (chk_reg_b != '0);
    supp        = ld_wins && (fwd_valid_a || fwd_valid_b);
`else
    fwd_data    = '0;
    fwd_valid_a = 1'b0;
    fwd_valid_b = 1'b0;
    supp        = 1'b0;
`endif
    // A load being forwarded this cycle no longer blocks decode on its register.
    stall = !reset && ((pend_q[chk_reg_a] && !(supp && chk_reg_a == sel_reg)) ||
                       (pend_q[chk_reg_b] && !(supp && chk_reg_b == sel_reg)) ||
                       (pend_q[chk_reg_d] && !(supp && chk_reg_d == sel_reg)));

    ld_count    = cnt_q;
    ld_overflow = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_reg_q  <= buf_reg_d;
    buf_data_q <= buf_data_d;
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: vector table, hand sequences, random vs queue model.
module tb_regfile_write_scheduler;
  localparam int LD_DEPTH = 2;
`ifdef REGFILE_SCHED_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk, reset;
  logic alu_wr_valid, ld_issue_valid, ld_valid, ld_ready, stall, reg_write_enable;
  logic [4:0] alu_wr_reg, ld_issue_reg, ld_reg, chk_reg_a, chk_reg_b, chk_reg_d, write_reg_rd;
  logic [31:0] alu_wr_data, ld_data, reg_write_data, fwd_data;
  logic fwd_valid_a, fwd_valid_b, ld_overflow;
  logic [1:0] ld_count;

  int checks = 0;
  int errors = 0;

  regfile_write_scheduler #(.LD_DEPTH(LD_DEPTH), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .alu_wr_valid(alu_wr_valid), .alu_wr_reg(alu_wr_reg), .alu_wr_data(alu_wr_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_reg(ld_issue_reg),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
    .chk_reg_a(chk_reg_a), .chk_reg_b(chk_reg_b), .chk_reg_d(chk_reg_d), .stall(stall),
    .reg_write_enable(reg_write_enable), .write_reg_rd(write_reg_rd), .reg_write_data(reg_write_data),
    .fwd_valid_a(fwd_valid_a), .fwd_valid_b(fwd_valid_b), .fwd_data(fwd_data),
    .ld_count(ld_count), .ld_overflow(ld_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic alu_v; logic [4:0] alu_r; logic [31:0] alu_d;
    logic ldv; logic [4:0] ldr; logic [31:0] ldd;
    logic iss_v; logic [4:0] iss_r;
    logic [4:0] ca, cb, cd;
    logic e_we; logic [4:0] e_rd; logic [31:0] e_dat;
    logic [1:0] e_cnt; logic e_rdy, e_stall, e_ovf;
  } vec_t;

  typedef struct { logic [4:0] r; logic [31:0] d; } ld_t;
  ld_t         mq[$];
  logic [31:0] mpend;
  logic        movf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                       input logic iv, input logic [4:0] ir,
                       input logic [4:0] ca, input logic [4:0] cb, input logic [4:0] cd);
    alu_wr_valid = av; alu_wr_reg = ar; alu_wr_data = ad;
    ld_valid = lv; ld_reg = lr; ld_data = ldd;
    ld_issue_valid = iv; ld_issue_reg = ir;
    chk_reg_a = ca; chk_reg_b = cb; chk_reg_d = cd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] ca);
    drive(0, 0, 0, 0, 0, 0, 0, 0, ca, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: one cycle, expectations straight from the arbitration and scoreboard rules.
  task automatic model_cycle();
    logic e_rdy, e_vld, e_we, pop, byp, fa, fb, supp, e_stall;
    logic [4:0] e_rd;
    logic [31:0] e_dat, e_fd;
    logic [4:0] cr [3];
    @(negedge clk);
    e_rdy = mq.size() < LD_DEPTH;
    e_vld = 0; e_rd = 0; e_dat = 0; pop = 0; byp = 0;
    if (alu_wr_valid) begin
      e_vld = 1; e_rd = alu_wr_reg; e_dat = alu_wr_data;
    end else if (mq.size() > 0) begin
      e_vld = 1; e_rd = mq[0].r; e_dat = mq[0].d; pop = 1;
    end else if (ld_valid && e_rdy) begin
      e_vld = 1; e_rd = ld_reg; e_dat = ld_data; byp = 1;
    end
    e_we = e_vld && e_rd != 0;
    fa   = FWD && e_we && e_rd == chk_reg_a && chk_reg_a != 0;
    fb   = FWD && e_we && e_rd == chk_reg_b && chk_reg_b != 0;
    e_fd = FWD ? e_dat : 32'h0;
    supp = (pop || byp) && (fa || fb);
    cr[0] = chk_reg_a; cr[1] = chk_reg_b; cr[2] = chk_reg_d;
    e_stall = 0;
    foreach (cr[i]) if (mpend[cr[i]] && !(supp && cr[i] == e_rd)) e_stall = 1;
    chk("rnd_we", 32'(reg_write_enable), 32'(e_we));
    chk("rnd_rd", 32'(write_reg_rd), 32'(e_rd));
    chk("rnd_data", reg_write_data, e_dat);
    chk("rnd_rdy", 32'(ld_ready), 32'(e_rdy));
    chk("rnd_cnt", 32'(ld_count), 32'(mq.size()));
    chk("rnd_stall", 32'(stall), 32'(e_stall));
    chk("rnd_ovf", 32'(ld_overflow), 32'(movf));
    chk("rnd_fwd_a", 32'(fwd_valid_a), 32'(fa));
    chk("rnd_fwd_b", 32'(fwd_valid_b), 32'(fb));
    chk("rnd_fwd_data", fwd_data, e_fd);
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (ld_valid && e_rdy && !byp) mq.push_back('{ld_reg, ld_data});
    if (ld_valid && !e_rdy) movf = 1;
    if ((pop || byp) && e_rd != 0) mpend[e_rd] = 0;
    if (ld_issue_valid && ld_issue_reg != 0) mpend[ld_issue_reg] = 1;
  endtask

  vec_t vt [9];

  initial begin
    vt[0] = '{0,0,0,           1,5,32'hDEADBEEF, 1,9, 0,0,0, 1,5,32'hDEADBEEF, 0,1,0,0};
    vt[1] = '{1,3,32'h11,      1,7,32'hA1,       0,0, 0,0,0, 1,3,32'h11,       0,1,0,0};
    vt[2] = '{1,3,32'h11,      1,8,32'hA2,       0,0, 0,0,0, 1,3,32'h11,       1,1,0,0};
    vt[3] = '{1,3,32'h11,      1,9,32'h99,       0,0, 0,0,0, 1,3,32'h11,       2,0,0,0};
    vt[4] = '{0,0,0,           0,0,0,            0,0, 0,0,9, 1,7,32'hA1,       2,0,1,1};
    vt[5] = '{0,0,0,           0,0,0,            0,0, 0,0,9, 1,8,32'hA2,       1,1,1,1};
    vt[6] = '{0,0,0,           0,0,0,            0,0, 0,0,9, 0,0,0,            0,1,1,1};
    vt[7] = '{0,0,0,           1,0,32'h55,       1,0, 0,0,0, 0,0,32'h55,       0,1,0,1};
    vt[8] = '{0,0,0,           0,0,0,            0,0, 0,0,0, 0,0,0,            0,1,0,1};

    do_reset();
    @(negedge clk);
    chk("rst_we", 32'(reg_write_enable), 0);
    chk("rst_cnt", 32'(ld_count), 0);
    chk("rst_rdy", 32'(ld_ready), 1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ovf", 32'(ld_overflow), 0);
    tick();

    foreach (vt[i]) begin
      drive(vt[i].alu_v, vt[i].alu_r, vt[i].alu_d, vt[i].ldv, vt[i].ldr, vt[i].ldd,
            vt[i].iss_v, vt[i].iss_r, vt[i].ca, vt[i].cb, vt[i].cd);
      @(negedge clk);
      chk($sformatf("vec%0d_we", i), 32'(reg_write_enable), 32'(vt[i].e_we));
      chk($sformatf("vec%0d_rd", i), 32'(write_reg_rd), 32'(vt[i].e_rd));
      chk($sformatf("vec%0d_data", i), reg_write_data, vt[i].e_dat);
      chk($sformatf("vec%0d_cnt", i), 32'(ld_count), 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d_rdy", i), 32'(ld_ready), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
      chk($sformatf("vec%0d_ovf", i), 32'(ld_overflow), 32'(vt[i].e_ovf));
      chk($sformatf("vec%0d_fwd_a", i), 32'(fwd_valid_a), 0);
      tick();
    end

    // Reset clears the sticky overflow and the leftover pending r9.
    do_reset();
    idle(9);
    @(negedge clk);
    chk("ovf_cleared", 32'(ld_overflow), 0);
    chk("r9_pend_cleared", 32'(stall), 0);
    tick();

    // RAW against an in-flight load to r4.
    drive(0, 0, 0, 0, 0, 0, 1, 4, 4, 0, 0);
    @(negedge clk);
    chk("r4_issue_cycle_stall", 32'(stall), 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      idle(4);
      @(negedge clk);
      chk($sformatf("r4_wait%0d_stall", c), 32'(stall), 1);
      tick();
    end
    drive(0, 0, 0, 1, 4, 32'hCAFE0004, 0, 0, 4, 0, 0);
    @(negedge clk);
    chk("r4_commit_we", 32'(reg_write_enable), 1);
    chk("r4_commit_rd", 32'(write_reg_rd), 4);
    chk("r4_commit_stall", 32'(stall), FWD ? 0 : 1);
    chk("r4_commit_fwd_a", 32'(fwd_valid_a), FWD ? 1 : 0);
    chk("r4_commit_fwd_data", fwd_data, FWD ? 32'hCAFE0004 : 32'h0);
    tick();
    idle(4);
    @(negedge clk);
    chk("r4_after_stall", 32'(stall), 0);
    tick();

    // Buffered load to r0 still pops with the write suppressed.
    drive(1, 2, 32'h22, 1, 0, 32'h77, 0, 0, 0, 0, 0);
    tick();
    idle(0);
    @(negedge clk);
    chk("r0_pop_we", 32'(reg_write_enable), 0);
    chk("r0_pop_cnt", 32'(ld_count), 1);
    tick();
    @(negedge clk);
    chk("r0_popped_cnt", 32'(ld_count), 0);
    tick();

    // Reset with two buffered entries and pending r6.
    drive(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    tick();
    drive(1, 1, 32'h1, 1, 10, 32'hB0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 32'h1, 1, 11, 32'hB1, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    idle(6);
    @(negedge clk);
    chk("inrst_cnt_before", 32'(ld_count), 2);
    chk("inrst_we", 32'(reg_write_enable), 0);
    chk("inrst_stall", 32'(stall), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_cnt", 32'(ld_count), 0);
    chk("postrst_stall", 32'(stall), 0);
    chk("postrst_rdy", 32'(ld_ready), 1);
    chk("postrst_we", 32'(reg_write_enable), 0);
    chk("postrst_rd", 32'(write_reg_rd), 0);
    chk("postrst_data", reg_write_data, 0);
    tick();

    // Random traffic against the queue model.
    do_reset();
    mq.delete();
    mpend = '0;
    movf  = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      model_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
